// File: rtl/cache_miss_arbiter.sv
// Shared memory-port miss controller for I/D caches: grants one miss, issues block reads, routes fills.
// Optional macro ROUND_ROBIN_EN alternates tie priority; otherwise D-cache always wins ties.
module cache_miss_arbiter #(
  parameter int WORDS_PER_BLOCK = 2,
  parameter int CNT_W           = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_out,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        icache_fill_wen,
  output logic        dcache_fill_wen,
  output logic        icache_tag_wen,
  output logic        dcache_tag_wen,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_grant_d;
  logic [15:0]      r_base;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic             w_favor_i;
  logic             w_any_miss;
  logic             w_grant_d;
  logic             w_ret;
  logic             w_ret_last;
  logic             w_issue_last;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [CNT_W-1:0] k);
    word_addr = base + ({{(16-CNT_W){1'b0}}, k} << 1);
  endfunction

  assign w_any_miss   = icache_miss | dcache_miss;
  assign w_grant_d    = dcache_miss & (~icache_miss | ~w_favor_i);
  // Returns only count while a fill is in flight; stray data in IDLE/DONE is dropped.
  assign w_ret        = mem_data_valid & ((r_state == S_ISSUE) | (r_state == S_WAIT));
  assign w_ret_last   = w_ret & (r_ret_cnt == LAST);
  assign w_issue_last = (r_state == S_ISSUE) & (r_issue_cnt == LAST);

`ifdef ROUND_ROBIN_EN
  logic r_favor_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_favor_i <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_favor_i <= r_grant_d;
    end
  end
  assign w_favor_i = r_favor_i;
`else
  assign w_favor_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant_d   <= 1'b0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
        if (w_any_miss) r_grant_d <= w_grant_d;
      end else begin
        if (r_state == S_ISSUE) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_ret)              r_ret_cnt   <= r_ret_cnt + CNT_W'(1);
      end
    end
  end

  // Block base is datapath only; it is never observed outside a granted fill.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_any_miss) begin
      r_base <= (w_grant_d ? dcache_miss_addr : icache_miss_addr) & 16'hFFFC;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_miss) w_next = S_ISSUE;
      S_ISSUE: if (w_issue_last) w_next = w_ret_last ? S_DONE : S_WAIT;
      S_WAIT:  if (w_ret_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en           = 1'b0;
    mem_addr         = '0;
    fill_addr        = '0;
    fill_data        = '0;
    icache_fill_wen  = 1'b0;
    dcache_fill_wen  = 1'b0;
    icache_tag_wen   = 1'b0;
    dcache_tag_wen   = 1'b0;
    icache_fill_done = 1'b0;
    dcache_fill_done = 1'b0;
    busy             = (r_state != S_IDLE);
    if (r_state == S_ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = word_addr(r_base, r_issue_cnt);
    end
    if (w_ret) begin
      fill_addr       = word_addr(r_base, r_ret_cnt);
      fill_data       = mem_data_out;
      icache_fill_wen = ~r_grant_d;
      dcache_fill_wen = r_grant_d;
    end
    if (r_state == S_DONE) begin
      icache_tag_wen   = ~r_grant_d;
      dcache_tag_wen   = r_grant_d;
      icache_fill_done = ~r_grant_d;
      dcache_fill_done = r_grant_d;
    end
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Randomized bench for cache_miss_arbiter with a transaction-schedule reference model.
module tb_cache_miss_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_miss = 1'b0, dcache_miss = 1'b0, mem_data_valid = 1'b0;
  logic [15:0] icache_miss_addr = '0, dcache_miss_addr = '0, mem_data_out = '0;
  logic        mem_en, busy;
  logic [15:0] mem_addr, fill_addr, fill_data;
  logic        icache_fill_wen, dcache_fill_wen, icache_tag_wen, dcache_tag_wen;
  logic        icache_fill_done, dcache_fill_done;

  always #5 clk = ~clk;

  cache_miss_arbiter #(.WORDS_PER_BLOCK(W), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
    .mem_en(mem_en), .mem_addr(mem_addr), .fill_addr(fill_addr), .fill_data(fill_data),
    .icache_fill_wen(icache_fill_wen), .dcache_fill_wen(dcache_fill_wen),
    .icache_tag_wen(icache_tag_wen), .dcache_tag_wen(dcache_tag_wen),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .busy(busy)
  );

  int n_vec = 0, n_err = 0, cyc = 0;

  // Reference model: a granted fill at cycle N is a fixed schedule of events.
  bit          m_known = 0, m_busy = 0, m_gd = 0, m_fav_i = 0, mem_act = 0;
  int          m_n = 0, m_l = 4, mem_n = 0, mem_l = 4;
  logic [15:0] m_base = '0;
  bit          i_pend = 0, d_pend = 0, do_rst = 1, stray_rand = 1;
  logic [15:0] i_addr = '0, d_addr = '0;
  int          regen_pct = 0, drop_pct = 0, stray_pct = 0, fix_l = 4;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int d, k, md;
    bit e_en, e_wr, e_done;
    logic [15:0] wdata;
    @(posedge clk); #1;
    cyc++;
    if (!i_pend && !(m_busy && !m_gd) && int'($urandom_range(0, 99)) < regen_pct) begin
      i_pend = 1; i_addr = 16'($urandom);
    end
    if (!d_pend && !(m_busy && m_gd) && int'($urandom_range(0, 99)) < regen_pct) begin
      d_pend = 1; d_addr = 16'($urandom);
    end
    d      = cyc - m_n;
    k      = d - 1 - m_l;
    e_en   = m_busy && d >= 1 && d <= W;
    e_wr   = m_busy && k >= 0 && k < W;
    e_done = m_busy && d == W + m_l + 1;
    md     = cyc - mem_n - 1 - mem_l;
    wdata  = 16'($urandom);
    mem_data_valid = 1'b0;
    if (mem_act && md >= 0 && md < W) begin
      mem_data_valid = 1'b1;
    end else if ((!m_busy || e_done) && int'($urandom_range(0, 99)) < stray_pct) begin
      mem_data_valid = 1'b1;
      if (!stray_rand) wdata = 16'hBEEF;
    end
    mem_data_out     = wdata;
    icache_miss      = i_pend;
    icache_miss_addr = i_addr;
    dcache_miss      = d_pend;
    dcache_miss_addr = d_addr;
    rst              = do_rst;
    #1;
    if (m_known) begin
      chk("busy", 16'(busy), 16'(m_busy));
      chk("mem_en", 16'(mem_en), 16'(e_en));
      if (e_en || !m_busy) chk("mem_addr", mem_addr, e_en ? m_base + 16'(2 * (d - 1)) : 16'h0);
      chk("icache_fill_wen", 16'(icache_fill_wen), 16'(e_wr && !m_gd));
      chk("dcache_fill_wen", 16'(dcache_fill_wen), 16'(e_wr && m_gd));
      if (e_wr) begin
        chk("fill_addr", fill_addr, m_base + 16'(2 * k));
        chk("fill_data", fill_data, wdata);
      end
      chk("icache_tag_wen", 16'(icache_tag_wen), 16'(e_done && !m_gd));
      chk("dcache_tag_wen", 16'(dcache_tag_wen), 16'(e_done && m_gd));
      chk("icache_fill_done", 16'(icache_fill_done), 16'(e_done && !m_gd));
      chk("dcache_fill_done", 16'(dcache_fill_done), 16'(e_done && m_gd));
    end
    if (do_rst) begin
      m_busy = 0; m_fav_i = 0;
    end else if (m_busy) begin
      if (e_done) begin
        m_busy = 0;
        if (m_gd) d_pend = 0; else i_pend = 0;
`ifdef ROUND_ROBIN_EN
        m_fav_i = m_gd;
`endif
      end else if (d == 1 && int'($urandom_range(0, 99)) < drop_pct) begin
        if (m_gd) d_pend = 0; else i_pend = 0;
      end
    end else if (i_pend || d_pend) begin
      m_gd    = d_pend && (!i_pend || !m_fav_i);
      m_base  = (m_gd ? d_addr : i_addr) & 16'hFFFC;
      m_l     = (fix_l > 0) ? fix_l : int'($urandom_range(1, 5));
      m_n     = cyc;
      m_busy  = 1;
      mem_act = 1;
      mem_n   = cyc;
      mem_l   = m_l;
    end
  endtask

  task automatic settle();
    regen_pct = 0; drop_pct = 0; stray_pct = 0; do_rst = 0;
    for (int i = 0; i < 80 && (m_busy || i_pend || d_pend); i++) step();
    if (m_busy || i_pend || d_pend) chk("settle_timeout", 16'(m_busy), 16'h0);
  endtask

  initial begin
    do_rst = 1;
    step();
    m_known = 1;
    step();
    do_rst = 0;

    // Single D miss at 16'h1237 with latency 4
    fix_l = 4;
    d_pend = 1; d_addr = 16'h1237;
    repeat (10) step();
    settle();

    // Simultaneous I and D misses
    i_pend = 1; i_addr = 16'h2A01;
    d_pend = 1; d_addr = 16'h5B02;
    repeat (20) step();
    settle();

    // Continuous tied misses from both caches
    regen_pct = 100;
    repeat (40) step();
    settle();

    // Reset at N+5 of an I fill, miss held so it restarts
    i_pend = 1; i_addr = 16'h4562;
    step();
    repeat (4) step();
    do_rst = 1;
    step();
    do_rst = 0;
    repeat (12) step();
    settle();

    // Stray memory data while idle
    stray_pct = 100; stray_rand = 0;
    repeat (6) step();
    stray_rand = 1; stray_pct = 0;

    // I miss dropped right after grant
    drop_pct = 100;
    i_pend = 1; i_addr = 16'h0F0D;
    repeat (10) step();
    settle();

    // Randomized traffic with random latency and occasional reset
    fix_l = 0;
    for (int i = 0; i < 3000; i++) begin
      regen_pct = 30; drop_pct = 15; stray_pct = 30;
      do_rst = ($urandom_range(0, 199) == 0);
      step();
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_miss_arbiter.md
# cache_miss_arbiter

Miss-service controller that sits between the instruction cache, the data cache and the single shared main-memory read port. It grants one pending miss at a time and issues the block's word reads to memory. It routes returned words into the winning cache's data array, then strobes that cache's tag/valid/LRU update for the filled set. Both caches use the 16-bit address split tag[15:8], set[7:2], offset[1:0] (byte offset; one block = two 16-bit words).

## Interface
Parameters:
- WORDS_PER_BLOCK, 2, words fetched per fill; must be a power of two ≥ 2.
- CNT_W, 2, width of the issue/return counters; must hold WORDS_PER_BLOCK.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- icache_miss  in  1  I-cache miss pending; held high until icache_fill_done.
- icache_miss_addr  in  16  I-cache missing address.
- dcache_miss  in  1  D-cache miss pending; held high until dcache_fill_done.
- dcache_miss_addr  in  16  D-cache missing address.
- mem_data_valid  in  1  memory returns one read word this cycle.
- mem_data_out  in  16  returned word.
- mem_en  out  1  issue one word read this cycle.
- mem_addr  out  16  read address.
- fill_addr  out  16  word address being written into the cache.
- fill_data  out  16  word being written; equals mem_data_out.
- icache_fill_wen, dcache_fill_wen  out  1 each  data-array write strobe.
- icache_tag_wen, dcache_tag_wen  out  1 each  one-cycle tag write, valid=1 and LRU update.
- icache_fill_done, dcache_fill_done  out  1 each  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any miss is pending, latch the grant (I or D) and base = addr & 16'hFFFC, then go to ISSUE.
- Arbitration: D-cache wins ties.
- ISSUE: one cycle per word, mem_en=1, mem_addr = base + 2·k for k = 0..WORDS_PER_BLOCK−1. After the last issue go to WAIT, or go straight to DONE if all words have already returned.
- Return: mem_data_valid is honored in ISSUE and WAIT only.
  - Each return asserts the granted cache's fill_wen.
  - fill_addr = base + 2·r, where r is the return counter; fill_data = mem_data_out.
  - Returns are in order.
- WAIT → DONE on the cycle the last word returns.
- DONE: one cycle. Assert the granted tag_wen and fill_done; go to IDLE.
- A miss request dropped mid-service does not abort the fill; the fill completes normally.
- mem_data_valid in IDLE or DONE is ignored: no strobes.
- Counters wrap modulo 2^CNT_W and are cleared on entry to ISSUE.

## Timing
- All outputs are 0 in reset and in IDLE; fill_addr/fill_data are don't-care when no fill_wen is high.
- Reset mid-fill: next cycle IDLE, all strobes 0, grant cleared; late memory returns are ignored.
- Miss first seen in IDLE at cycle N:
  - mem_en in cycles N+1..N+WORDS_PER_BLOCK.
  - With memory latency L, word k is written at cycle N+1+k+L.
  - DONE is the cycle after the last write; IDLE the cycle after DONE.
  - Defaults (L=4, 2 words): writes at N+5 and N+6, DONE at N+7, next grant evaluated at N+8.
- Outputs are combinational from state and registered grant/base; mem_addr has no combinational path from the miss inputs.
- Never more than one fill_wen, tag_wen or fill_done high in any cycle.

## Configuration
- ROUND_ROBIN_EN defined: a priority flag toggles after every DONE. On a tie, the requester not served last wins; the flag resets to favor D.
- Undefined: fixed D-over-I priority; the I-cache can starve under continuous D misses.

## Test plan
- Single D miss, addr 16'h1237, L=4 → mem_addr 1234 then 1236 at N+1 and N+2; dcache_fill_wen at N+5 (fill_addr 1234) and N+6 (fill_addr 1236); dcache_tag_wen and dcache_fill_done at N+7 only.
- I and D miss in the same cycle, without ROUND_ROBIN_EN → D is served first; I is granted at N+8, so I's mem_en is at N+9.
- Back-to-back simultaneous misses with ROUND_ROBIN_EN → service order D, I, D, I, and the I-cache never starves.
- rst asserted at N+5 of an I fill → IDLE at N+6; the word arriving at N+6 causes no icache_fill_wen; a subsequent miss restarts from base.
- Stray mem_data_valid in IDLE with data 16'hBEEF → all fill_wen, tag_wen and done outputs stay 0.
- icache_miss dropped at N+2 → the fill still completes and icache_fill_done pulses at N+7.
